// File: rtl/lvl_detect.sv
`default_nettype none
// ============================================================================
// Module   : lvl_detect
// Purpose  : Hysteretic level detector with persistence qualification, peak
//            capture and a saturating event counter on a filtered sample stream.
// Revision : 1.0 - initial release
// ============================================================================
module lvl_detect #(
  parameter int WIDTH = 10,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    clear,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic signed [WIDTH-1:0] thr_hi,
  input  logic signed [WIDTH-1:0] thr_lo,
  input  logic        [CNT_W-1:0] persist,
  output logic                    det_out,
  output logic                    rise_pulse,
  output logic                    fall_pulse,
  output logic signed [WIDTH-1:0] peak_out,
  output logic        [CNT_W-1:0] evt_cnt,
  output logic        [1:0]       state_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    ACTIVE = 2'd2,
    REL    = 2'd3
  } state_t;

  localparam logic signed [WIDTH-1:0] c_PEAK_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic        [CNT_W-1:0] c_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t                    r_state,    w_state;
  logic        [CNT_W-1:0]   r_cnt,      w_cnt;
  logic                      r_det,      w_det;
  logic                      r_rise,     w_rise;
  logic                      r_fall,     w_fall;
  logic signed [WIDTH-1:0]   r_peak_out, w_peak_out;
  logic        [CNT_W-1:0]   r_evt_cnt,  w_evt_cnt;
  logic signed [WIDTH-1:0]   r_run_peak, w_run_peak;

  logic                      w_hi;
  logic                      w_lo;
  logic        [CNT_W-1:0]   w_p;
  logic                      w_p_one;
  logic        [CNT_W:0]     w_cnt_inc;
  logic                      w_cnt_done;
  logic signed [WIDTH-1:0]   w_peak_max;
  logic        [CNT_W-1:0]   w_evt_sat;

  assign w_hi       = (x_in >= thr_hi);
  assign w_lo       = (x_in <= thr_lo);
  assign w_p        = (persist == '0) ? c_CNT_ONE : persist;
  assign w_p_one    = (w_p == c_CNT_ONE);
  assign w_cnt_inc  = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
  // >= rather than == so a persist reduced below the running count still completes
  assign w_cnt_done = (w_cnt_inc >= {1'b0, w_p});
  assign w_peak_max = (x_in > r_run_peak) ? x_in : r_run_peak;
  assign w_evt_sat  = (r_evt_cnt == '1) ? r_evt_cnt : r_evt_cnt + c_CNT_ONE;

  always_comb begin
    w_state    = r_state;
    w_cnt      = r_cnt;
    w_det      = r_det;
    w_rise     = 1'b0;
    w_fall     = 1'b0;
    w_peak_out = r_peak_out;
    w_evt_cnt  = r_evt_cnt;
    w_run_peak = r_run_peak;
    if (clear) begin
      w_state    = IDLE;
      w_cnt      = '0;
      w_det      = 1'b0;
      w_peak_out = '0;
      w_evt_cnt  = '0;
      w_run_peak = c_PEAK_MIN;
    end else if (en) begin
      case (r_state)
        IDLE: begin
          if (w_hi) begin
            w_run_peak = w_peak_max;
            if (w_p_one) begin
              w_state   = ACTIVE;
              w_cnt     = '0;
              w_det     = 1'b1;
              w_rise    = 1'b1;
              w_evt_cnt = w_evt_sat;
            end else begin
              w_state = ARM;
              w_cnt   = c_CNT_ONE;
            end
          end else begin
            w_cnt = '0;
          end
        end
        ARM: begin
          if (w_hi) begin
            w_run_peak = w_peak_max;
            if (w_cnt_done) begin
              w_state   = ACTIVE;
              w_cnt     = '0;
              w_det     = 1'b1;
              w_rise    = 1'b1;
              w_evt_cnt = w_evt_sat;
            end else begin
              w_cnt = w_cnt_inc[CNT_W-1:0];
            end
          end else begin
            w_state    = IDLE;
            w_cnt      = '0;
            w_run_peak = c_PEAK_MIN;
          end
        end
        ACTIVE: begin
          w_run_peak = w_peak_max;
          if (w_lo) begin
            if (w_p_one) begin
              w_state    = IDLE;
              w_cnt      = '0;
              w_det      = 1'b0;
              w_fall     = 1'b1;
              w_peak_out = w_peak_max;
              w_run_peak = c_PEAK_MIN;
            end else begin
              w_state = REL;
              w_cnt   = c_CNT_ONE;
            end
          end
        end
        REL: begin
          w_run_peak = w_peak_max;
          if (w_lo) begin
            if (w_cnt_done) begin
              w_state    = IDLE;
              w_cnt      = '0;
              w_det      = 1'b0;
              w_fall     = 1'b1;
              w_peak_out = w_peak_max;
              w_run_peak = c_PEAK_MIN;
            end else begin
              w_cnt = w_cnt_inc[CNT_W-1:0];
            end
          end else begin
            w_state = ACTIVE;
            w_cnt   = '0;
          end
        end
        default: begin
          w_state = IDLE;
          w_cnt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_det      <= 1'b0;
      r_rise     <= 1'b0;
      r_fall     <= 1'b0;
      r_peak_out <= '0;
      r_evt_cnt  <= '0;
      r_run_peak <= c_PEAK_MIN;
    end else begin
      r_state    <= w_state;
      r_cnt      <= w_cnt;
      r_det      <= w_det;
      r_rise     <= w_rise;
      r_fall     <= w_fall;
      r_peak_out <= w_peak_out;
      r_evt_cnt  <= w_evt_cnt;
      r_run_peak <= w_run_peak;
    end
  end

  assign det_out    = r_det;
  assign rise_pulse = r_rise;
  assign fall_pulse = r_fall;
  assign peak_out   = r_peak_out;
  assign evt_cnt    = r_evt_cnt;
  assign state_out  = r_state;

endmodule
`default_nettype wire
